// File: rtl/coe_pkg.sv
// Shared constants and types for the coefficient fetch controller.
// Holds the default widths, output-buffer depth and FSM state encoding.
package coe_pkg;

    localparam int ADDR_W     = 5;
    localparam int COE_W      = 7;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/coe_fifo2.sv
// Two-entry output buffer holding ROM word, burst index and last flag.
// The head entry is exposed directly so it stays stable until popped.
module coe_fifo2 #(
    parameter int DATA_W = 14,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [IDX_W-1:0]  push_index,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [IDX_W-1:0]  head_index,
    output logic              head_last,
    output logic              valid,
    output logic [1:0]        count
);
    import coe_pkg::*;

    localparam int EW    = DATA_W + IDX_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [PTR_W-1:0]                wr_ptr_reg;
    logic [PTR_W-1:0]                rd_ptr_reg;
    logic [1:0]                      count_reg;
    logic [FIFO_DEPTH-1:0][EW-1:0]   entry_bus;
    logic [EW-1:0]                   head_entry;

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [EW-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (srst) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= {push_last, push_index, push_data};
                end
            end
            assign entry_bus[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + 2'(push) - 2'(pop);
        end
    end

    assign head_entry = entry_bus[rd_ptr_reg];
    assign head_data  = head_entry[DATA_W-1:0];
    assign head_index = head_entry[DATA_W +: IDX_W];
    assign head_last  = head_entry[EW-1];
    assign valid      = (count_reg != 2'd0);
    assign count      = count_reg;

endmodule

// File: rtl/coe_fetch_ctrl.sv
// Coefficient fetch controller: issues a burst of ROM reads with credit-based
// flow control and presents the returned words through a 2-entry buffer.
module coe_fetch_ctrl #(
    parameter int ADDR_W = coe_pkg::ADDR_W,
    parameter int COE_W  = coe_pkg::COE_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      len,
    output logic                 busy,
    output logic [6:0]           rom_addr,
    input  logic [2*COE_W-1:0]   rom_q,
    output logic [COE_W-1:0]     coe1_out,
    output logic [COE_W-1:0]     coe2_out,
    output logic                 coe_valid,
    input  logic                 coe_ready,
    output logic [ADDR_W-1:0]    coe_index,
    output logic                 coe_last,
    output logic                 done
);
    import coe_pkg::*;

    state_t              state_reg, state_next;
    logic [ADDR_W:0]     len_reg;
    logic [ADDR_W:0]     issued_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                inflight_reg;
    logic [ADDR_W-1:0]   infl_index_reg;
    logic                infl_last_reg;
    logic                done_reg;

    logic                accept, pop, credit, issue, issue_last;
    logic [1:0]          fifo_count;
    logic [2*COE_W-1:0]  head_data;
    logic                head_last;

    assign accept     = (state_reg == IDLE) && start;
    assign pop        = coe_valid && coe_ready;
    // A pop in the same cycle frees a slot for the word issued now.
    assign credit     = ({1'b0, fifo_count} + {2'b00, inflight_reg}) <= (3'd1 + {2'b00, pop});
    assign issue      = (state_reg == FETCH) && credit;
    assign issue_last = issue && (issued_reg == (len_reg - (ADDR_W+1)'(1)));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && (len != '0)) state_next = FETCH;
            FETCH:   if (issue_last)           state_next = DRAIN;
            DRAIN:   if (pop && coe_last)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            issued_reg     <= '0;
            addr_reg       <= '0;
            inflight_reg   <= 1'b0;
            infl_index_reg <= '0;
            infl_last_reg  <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            inflight_reg   <= issue;
            infl_index_reg <= issued_reg[ADDR_W-1:0];
            infl_last_reg  <= issue_last;
            done_reg       <= (accept && (len == '0)) ||
                              ((state_reg == DRAIN) && pop && coe_last);
            if (accept) begin
                len_reg    <= len;
                issued_reg <= '0;
                if (len != '0) addr_reg <= base_addr;
            end else if (issue) begin
                issued_reg <= issued_reg + 1'b1;
                // Stop advancing on the final word so the bus holds it afterwards.
                if (!issue_last) addr_reg <= addr_reg + 1'b1;
            end
        end
    end

    coe_fifo2 #(
        .DATA_W (2*COE_W),
        .IDX_W  (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .srst       (reset),
        .push       (inflight_reg),
        .push_data  (rom_q),
        .push_index (infl_index_reg),
        .push_last  (infl_last_reg),
        .pop        (pop),
        .head_data  (head_data),
        .head_index (coe_index),
        .head_last  (head_last),
        .valid      (coe_valid),
        .count      (fifo_count)
    );

    assign coe1_out = head_data[COE_W-1:0];
    assign coe2_out = head_data[2*COE_W-1:COE_W];
    assign coe_last = coe_valid && head_last;
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign rom_addr = 7'(addr_reg);

endmodule

// File: doc/coe_fetch_ctrl.md
COE_FETCH_CTRL -- requirements
Module: coe_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning the coefficient ROM word-address width (32 words).
REQ-002 The block SHALL have parameter COE_W, default 7, meaning the width of each coefficient.
REQ-003 The block SHALL have these ports (clock and reset first):
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a fetch burst.
- base_addr  in  ADDR_W  first ROM word of the burst.
- len  in  ADDR_W+1  words in the burst, 0..32.
- busy  out  1  burst in progress.
- rom_addr  out  7  ROM word address; upper 7-ADDR_W bits tied 0.
- rom_q  in  2*COE_W  ROM data, valid one cycle after rom_addr.
- coe1_out  out  COE_W  rom_q[COE_W-1:0] of the head word.
- coe2_out  out  COE_W  rom_q[2*COE_W-1:COE_W] of the head word.
- coe_valid  out  1  head word available.
- coe_ready  in  1  consumer accepts the head word.
- coe_index  out  ADDR_W  burst-relative index of the head word.
- coe_last  out  1  head word is the final word of the burst.
- done  out  1  one-cycle pulse at burst completion.

Function
REQ-004 The FSM SHALL have states IDLE, FETCH, DRAIN.
REQ-005 In IDLE, start=1 SHALL latch base_addr and len; len>0 goes to FETCH; len=0 stays in IDLE and pulses done next cycle.
REQ-006 In FETCH and DRAIN, start SHALL be ignored.
REQ-007 In FETCH, the block SHALL issue one address per cycle when credit permits: rom_addr=(base+issued) mod 32, wrapping 31->0.
REQ-008 An issue SHALL be permitted only when fifo_count + inflight - pop <= 1, where pop = coe_valid&&coe_ready; the 2-entry output FIFO never overflows.
REQ-009 Each rom_q SHALL be written to the FIFO in the cycle after its address was issued, with its index and last flag.
REQ-010 FETCH SHALL go to DRAIN after issuing word len-1; DRAIN SHALL go to IDLE when the coe_last word is popped.
REQ-011 done SHALL pulse in the cycle after the coe_last pop; busy SHALL be 1 from the cycle after start is accepted until done.
REQ-012 With coe_ready held high, the first coe_valid SHALL occur 3 cycles after start is sampled, and one word SHALL follow per cycle with no bubbles.
REQ-013 Once asserted, coe_valid and the head data, index and last SHALL stay stable until popped.
REQ-014 A simultaneous FIFO write and pop SHALL leave fifo_count unchanged.
REQ-015 Outside a burst, rom_addr SHALL hold its last value, and rom_q SHALL be ignored.

Reset
REQ-016 When reset=1 at a clock edge, the block SHALL enter IDLE, clear the FIFO, inflight, issued and latched len, and drive busy=0, coe_valid=0, done=0, coe_last=0, coe_index=0, rom_addr=0.
REQ-017 Reset mid-burst SHALL abort the burst with no done pulse, and data still in flight SHALL be discarded.
REQ-018 Reset SHALL take priority over start in the same cycle.

Structure
REQ-019 ADDR_W, COE_W, the FSM state enum and the FIFO depth constant (2) SHALL live in the shared package coe_pkg.
REQ-020 The 2-entry output buffer SHALL be a separate sub-module, coe_fifo2 (data, index, last; push/pop/count).
REQ-021 The block SHALL connect directly to ROM_wrapper-style ROM ports (rom_addr out, 14-bit word in) with no extra glue.

Verification
ROM model: 1-cycle latency, q[6:0]=addr, q[13:7]=addr+64.
REQ-022 start, base=4, len=3, ready=1 -> coe_valid 3 cycles later; (coe1,coe2) = (4,68),(5,69),(6,70) on consecutive cycles; coe_last on the 3rd; done the next cycle.
REQ-023 base=30, len=4 -> coe1 sequence 30,31,0,1; coe_index 0..3.
REQ-024 len=5, ready toggled 1,0,0,1,... -> all 5 words in order, none lost or duplicated, head data stable while ready=0, rom_addr issues stall.
REQ-025 start with len=0 -> no coe_valid; done pulses 1 cycle later; busy stays 0.
REQ-026 start during a burst (base=10) -> ignored, original burst unaffected.
REQ-027 reset asserted after the 2nd word of a len=8 burst -> all outputs 0 next cycle, no done; a new burst base=0, len=2 then yields (0,64),(1,65).
